// File: rtl/fifo_prog.sv
// fifo_prog: parametrised single-clock FIFO with arbitrary depth, programmable
// almost-full/almost-empty thresholds, occupancy count and optional
// first-word-fall-through read mode.
module fifo_prog #(
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
   parameter int unsigned AE_LEVEL   = 1,
   parameter int unsigned FWFT       = 0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                wr_en,
   input  logic [FIFO_WIDTH-1:0]               data_in,
   input  logic                                rd_en,
   output logic [FIFO_WIDTH-1:0]               data_out,
   output logic                                wr_ack,
   output logic                                overflow,
   output logic                                underflow,
   output logic                                full,
   output logic                                empty,
   output logic                                almostfull,
   output logic                                almostempty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     count
);

   localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam bit          FWFT_MODE = (FWFT != 0);

   // Reject illegal threshold/depth combinations while elaborating
   if (!((AE_LEVEL >= 1) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= FIFO_DEPTH - 1)))
   begin : g_bad_params
      $error("fifo_prog: need 1 <= AE_LEVEL < AF_LEVEL <= FIFO_DEPTH-1");
   end

   logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  wr_do;
   logic                  rd_do;

   // Status flags are pure decodes of the occupancy count
   always_comb begin
      full        = (count == CW'(FIFO_DEPTH));
      empty       = (count == '0);
      almostfull  = (count >= CW'(AF_LEVEL)) && !full;
      almostempty = !empty && (count <= CW'(AE_LEVEL));
   end

   // Accept decisions; a push into a full FIFO rides on a same-cycle pop only in FWFT mode
   always_comb begin
      rd_do = rd_en && !empty;
      wr_do = wr_en && (!full || (rd_en && FWFT_MODE));
   end

   // Storage array, deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_do) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers wrap explicitly so any depth works; count tracks net push/pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_do) begin
            wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (rd_do) begin
            rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         case ({wr_do, rd_do})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Handshake pulses describe the request sampled at the previous edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         wr_ack    <= wr_do;
         overflow  <= wr_en && !wr_do;
         underflow <= rd_en && empty;
      end
   end

   if (FWFT_MODE) begin : g_fwft
      // Head word falls through combinationally; forced to zero while empty
      always_comb begin
         data_out = empty ? '0 : mem[rd_ptr];
      end
   end else begin : g_reg_read
      // Registered read: load the head word on an accepted pop, hold otherwise
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_out <= '0;
         end else if (rd_do) begin
            data_out <= mem[rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_fifo_prog.sv
// Directed bench for fifo_prog: registered-read, FWFT and depth-5 instances.
module tb_fifo_prog;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   // Instance a: depth 8, AF=6, AE=2, registered read
   logic        a_wr_en, a_rd_en, a_wr_ack, a_overflow, a_underflow;
   logic        a_full, a_empty, a_af, a_ae;
   logic [15:0] a_din, a_dout;
   logic [3:0]  a_count;

   // Instance b: depth 8, AF=6, AE=2, first-word-fall-through
   logic        b_wr_en, b_rd_en, b_wr_ack, b_overflow, b_underflow;
   logic        b_full, b_empty, b_af, b_ae;
   logic [15:0] b_din, b_dout;
   logic [3:0]  b_count;

   // Instance c: depth 5, default thresholds, registered read
   logic        c_wr_en, c_rd_en, c_wr_ack, c_overflow, c_underflow;
   logic        c_full, c_empty, c_af, c_ae;
   logic [15:0] c_din, c_dout;
   logic [2:0]  c_count;

   fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_a (
      .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .data_in(a_din), .rd_en(a_rd_en),
      .data_out(a_dout), .wr_ack(a_wr_ack), .overflow(a_overflow), .underflow(a_underflow),
      .full(a_full), .empty(a_empty), .almostfull(a_af), .almostempty(a_ae), .count(a_count));

   fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_b (
      .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .data_in(b_din), .rd_en(b_rd_en),
      .data_out(b_dout), .wr_ack(b_wr_ack), .overflow(b_overflow), .underflow(b_underflow),
      .full(b_full), .empty(b_empty), .almostfull(b_af), .almostempty(b_ae), .count(b_count));

   fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(0)) u_c (
      .clk(clk), .rst_n(rst_n), .wr_en(c_wr_en), .data_in(c_din), .rd_en(c_rd_en),
      .data_out(c_dout), .wr_ack(c_wr_ack), .overflow(c_overflow), .underflow(c_underflow),
      .full(c_full), .empty(c_empty), .almostfull(c_af), .almostempty(c_ae), .count(c_count));

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_wr_en = 0; a_rd_en = 0; a_din = '0;
      b_wr_en = 0; b_rd_en = 0; b_din = '0;
      c_wr_en = 0; c_rd_en = 0; c_din = '0;
      #3;
      checks++;
      if ({a_count, a_empty, a_full, a_af, a_ae, a_wr_ack, a_overflow, a_underflow} !== {4'd0, 1'b1, 6'b0}) begin
         errors++;
         $display("FAIL reset_flags_a: got cnt=%0d e=%b f=%b af=%b ae=%b ack=%b ov=%b un=%b, want cnt=0 e=1 rest 0",
                  a_count, a_empty, a_full, a_af, a_ae, a_wr_ack, a_overflow, a_underflow);
      end
      checks++;
      if (a_dout !== 16'h0) begin
         errors++;
         $display("FAIL reset_dout_a: got %h want 0000", a_dout);
      end
      checks++;
      if ({c_count, c_empty, b_count, b_empty} !== {3'd0, 1'b1, 4'd0, 1'b1}) begin
         errors++;
         $display("FAIL reset_bc: got c_cnt=%0d c_e=%b b_cnt=%0d b_e=%b want 0 1 0 1", c_count, c_empty, b_count, b_empty);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // Fill 1..8 checking acks and thresholds, then drain in order
   task automatic test_fill_drain();
      int acks = 0;
      logic exp_af, exp_ae;
      for (int i = 1; i <= 8; i++) begin
         a_wr_en = 1; a_din = 16'(i);
         tick();
         if (a_wr_ack === 1'b1) acks++;
         exp_af = (i >= 6) && (i < 8);
         exp_ae = (i >= 1) && (i <= 2);
         checks++;
         if ({a_count, a_af, a_ae} !== {4'(i), exp_af, exp_ae}) begin
            errors++;
            $display("FAIL fill_level_%0d: got cnt=%0d af=%b ae=%b want cnt=%0d af=%b ae=%b",
                     i, a_count, a_af, a_ae, i, exp_af, exp_ae);
         end
      end
      a_wr_en = 0;
      checks++;
      if (acks != 8 || a_full !== 1'b1 || a_count !== 4'd8) begin
         errors++;
         $display("FAIL fill_done: got acks=%0d full=%b cnt=%0d want 8 1 8", acks, a_full, a_count);
      end
      for (int i = 1; i <= 8; i++) begin
         a_rd_en = 1;
         tick();
         exp_af = ((8 - i) >= 6) && ((8 - i) < 8);
         exp_ae = ((8 - i) >= 1) && ((8 - i) <= 2);
         checks++;
         if ({a_dout, a_count, a_underflow, a_af, a_ae} !== {16'(i), 4'(8 - i), 1'b0, exp_af, exp_ae}) begin
            errors++;
            $display("FAIL drain_%0d: got d=%h cnt=%0d un=%b af=%b ae=%b want d=%h cnt=%0d un=0 af=%b ae=%b",
                     i, a_dout, a_count, a_underflow, a_af, a_ae, 16'(i), 8 - i, exp_af, exp_ae);
         end
      end
      a_rd_en = 0;
      checks++;
      if (a_empty !== 1'b1) begin
         errors++;
         $display("FAIL drain_empty: got empty=%b want 1", a_empty);
      end
   endtask

   // Overflow on full, then full+both in registered mode, then underflow on empty
   task automatic test_over_underflow();
      for (int i = 1; i <= 8; i++) begin
         a_wr_en = 1; a_din = 16'h0010 + 16'(i);
         tick();
      end
      a_din = 16'hDEAD;
      tick();
      a_wr_en = 0;
      checks++;
      if ({a_overflow, a_wr_ack, a_count} !== {1'b1, 1'b0, 4'd8}) begin
         errors++;
         $display("FAIL overflow: got ov=%b ack=%b cnt=%0d want 1 0 8", a_overflow, a_wr_ack, a_count);
      end
      a_wr_en = 1; a_rd_en = 1; a_din = 16'hBAD0;
      tick();
      a_wr_en = 0; a_rd_en = 0;
      checks++;
      if ({a_overflow, a_wr_ack, a_count, a_dout} !== {1'b1, 1'b0, 4'd7, 16'h0011}) begin
         errors++;
         $display("FAIL full_both_reg: got ov=%b ack=%b cnt=%0d d=%h want 1 0 7 0011",
                  a_overflow, a_wr_ack, a_count, a_dout);
      end
      for (int i = 2; i <= 8; i++) begin
         a_rd_en = 1;
         tick();
         checks++;
         if (a_dout !== 16'h0010 + 16'(i)) begin
            errors++;
            $display("FAIL after_full_both_%0d: got %h want %h", i, a_dout, 16'h0010 + 16'(i));
         end
      end
      tick();
      a_rd_en = 0;
      checks++;
      if ({a_underflow, a_dout, a_count, a_empty} !== {1'b1, 16'h0018, 4'd0, 1'b1}) begin
         errors++;
         $display("FAIL underflow: got un=%b d=%h cnt=%0d e=%b want 1 0018 0 1", a_underflow, a_dout, a_count, a_empty);
      end
   endtask

   // Simultaneous push/pop on empty and at mid occupancy
   task automatic test_simultaneous();
      logic [15:0] exp_q [4] = '{16'h0057, 16'h0058, 16'h0059, 16'h005A};
      a_wr_en = 1; a_rd_en = 1; a_din = 16'h0055;
      tick();
      a_rd_en = 0;
      checks++;
      if ({a_count, a_underflow, a_wr_ack} !== {4'd1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL empty_both: got cnt=%0d un=%b ack=%b want 1 1 1", a_count, a_underflow, a_wr_ack);
      end
      for (int i = 0; i < 3; i++) begin
         a_din = 16'h0056 + 16'(i);
         tick();
      end
      a_rd_en = 1; a_din = 16'h0059;
      tick();
      checks++;
      if ({a_count, a_dout} !== {4'd4, 16'h0055}) begin
         errors++;
         $display("FAIL mid_both_1: got cnt=%0d d=%h want 4 0055", a_count, a_dout);
      end
      a_din = 16'h005A;
      tick();
      a_wr_en = 0;
      checks++;
      if ({a_count, a_dout} !== {4'd4, 16'h0056}) begin
         errors++;
         $display("FAIL mid_both_2: got cnt=%0d d=%h want 4 0056", a_count, a_dout);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (a_dout !== exp_q[i]) begin
            errors++;
            $display("FAIL mid_order_%0d: got %h want %h", i, a_dout, exp_q[i]);
         end
      end
      a_rd_en = 0;
      tick();
   endtask

   // FWFT: fall-through on empty, push+pop while full
   task automatic test_fwft();
      b_wr_en = 1; b_din = 16'hBEEF;
      tick();
      b_wr_en = 0;
      checks++;
      if ({b_dout, b_empty, b_count} !== {16'hBEEF, 1'b0, 4'd1}) begin
         errors++;
         $display("FAIL fwft_fall_through: got d=%h e=%b cnt=%0d want BEEF 0 1", b_dout, b_empty, b_count);
      end
      b_wr_en = 1;
      for (int i = 2; i <= 8; i++) begin
         b_din = 16'hB000 + 16'(i);
         tick();
      end
      b_rd_en = 1; b_din = 16'hC000;
      tick();
      b_wr_en = 0; b_rd_en = 0;
      checks++;
      if ({b_count, b_overflow, b_wr_ack, b_full, b_dout} !== {4'd8, 1'b0, 1'b1, 1'b1, 16'hB002}) begin
         errors++;
         $display("FAIL fwft_full_both: got cnt=%0d ov=%b ack=%b f=%b d=%h want 8 0 1 1 B002",
                  b_count, b_overflow, b_wr_ack, b_full, b_dout);
      end
      b_rd_en = 1;
      tick();
      b_rd_en = 0;
      checks++;
      if ({b_dout, b_count} !== {16'hB003, 4'd7}) begin
         errors++;
         $display("FAIL fwft_pop: got d=%h cnt=%0d want B003 7", b_dout, b_count);
      end
   endtask

   // Depth-5 stream of 20 words with interleaved push/pop across several wraps
   task automatic test_wrap();
      logic [15:0] q [$];
      logic [15:0] exp_d;
      int          sent = 0;
      int          got = 0;
      int          cyc = 0;
      int          bad = 0;
      logic        wr, rd;
      while (got < 20 && cyc < 300) begin
         wr = (sent < 20) && (q.size() < 5) && ((cyc % 3) != 2);
         rd = (q.size() > 0) && (((cyc % 4) != 0) || (sent == 20));
         c_wr_en = wr; c_rd_en = rd; c_din = 16'h0100 + 16'(sent);
         tick();
         if (rd) begin
            exp_d = q.pop_front();
            got++;
            checks++;
            if (c_dout !== exp_d) begin
               errors++;
               $display("FAIL wrap_data_%0d: got %h want %h", got, c_dout, exp_d);
            end
         end
         if (wr) begin
            q.push_back(16'h0100 + 16'(sent));
            sent++;
         end
         if (c_count !== 3'(q.size()) || c_count > 3'd5 || c_wr_ack !== wr) bad++;
         cyc++;
      end
      c_wr_en = 0; c_rd_en = 0;
      checks++;
      if (got != 20) begin
         errors++;
         $display("FAIL wrap_timeout: got %0d words want 20", got);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wrap_count: got %0d bad cycles want 0", bad);
      end
   endtask

   // Asynchronous reset asserted mid-cycle with count 3 acts without an edge
   task automatic test_async_reset();
      a_wr_en = 1;
      for (int i = 0; i < 3; i++) begin
         a_din = 16'h0A00 + 16'(i);
         tick();
      end
      a_wr_en = 0;
      a_rd_en = 1;
      tick();
      a_rd_en = 0;
      a_wr_en = 1; a_din = 16'h0A03;
      tick();
      a_wr_en = 0;
      checks++;
      if ({a_count, a_wr_ack, a_dout} !== {4'd3, 1'b1, 16'h0A00}) begin
         errors++;
         $display("FAIL pre_reset: got cnt=%0d ack=%b d=%h want 3 1 0A00", a_count, a_wr_ack, a_dout);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a_count, a_empty, a_full, a_af, a_ae, a_wr_ack, a_overflow, a_underflow, a_dout} !==
          {4'd0, 1'b1, 6'b0, 16'h0}) begin
         errors++;
         $display("FAIL async_reset_a: got cnt=%0d e=%b f=%b af=%b ae=%b ack=%b ov=%b un=%b d=%h",
                  a_count, a_empty, a_full, a_af, a_ae, a_wr_ack, a_overflow, a_underflow, a_dout);
      end
      checks++;
      if ({b_count, b_full, b_empty} !== {4'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL async_reset_b: got cnt=%0d f=%b e=%b want 0 0 1", b_count, b_full, b_empty);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if ({a_count, a_empty} !== {4'd0, 1'b1}) begin
         errors++;
         $display("FAIL post_reset: got cnt=%0d e=%b want 0 1", a_count, a_empty);
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_over_underflow();
      test_simultaneous();
      test_fwft();
      test_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
